// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single regfile write port; REGWB_FWD_EN adds rs1/rs2 bypass of the output stage.
// Latency: grant is combinational in cycle N, the registered write appears on o_rd_* in cycle N+1.
// Backpressure: o_req_ready low holds requesters; i_stall blocks every accept, including zero-address ones.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  localparam int GID_W  = $clog2(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_stall,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [ADDR_W-1:0]         o_rd_addr,
  output logic [DATA_W-1:0]         o_rd_data,
  output logic                      o_rd_wren,
  output logic [GID_W-1:0]          o_grant_id
`ifdef REGWB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]         i_rs1_addr,
  input  logic [ADDR_W-1:0]         i_rs2_addr,
  input  logic [DATA_W-1:0]         i_rs1_rf_data,
  input  logic [DATA_W-1:0]         i_rs2_rf_data,
  output logic [DATA_W-1:0]         o_rs1_data,
  output logic [DATA_W-1:0]         o_rs2_data
`endif
);

  logic [ADDR_W-1:0]  req_addr [NUM_REQ];
  logic [DATA_W-1:0]  req_data [NUM_REQ];
  logic [NUM_REQ-1:0] zero_acc;
  logic [NUM_REQ-1:0] elig;
  logic [GID_W-1:0]   rr_ptr;
  logic [GID_W-1:0]   ptr_nxt;
  logic [GID_W-1:0]   grant_idx;
  logic [GID_W-1:0]   cand;
  logic               grant_vld;
  int                 idx;

  // Zero-address writes are no-ops, so they are accepted in parallel and never arbitrate.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_addr[k] = i_req_addr[k*ADDR_W +: ADDR_W];
      req_data[k] = i_req_data[k*DATA_W +: DATA_W];
      zero_acc[k] = !i_stall && i_req_valid[k] && (req_addr[k] == '0);
      elig[k]     = !i_stall && i_req_valid[k] && (req_addr[k] != '0);
    end
  end

  // Walk the rotation from the far end back to the pointer so the nearest eligible requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    cand      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = GID_W'(idx);
      if (elig[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      o_req_ready[k] = zero_acc[k] | (grant_vld && (grant_idx == GID_W'(k)));
    end
    ptr_nxt = (grant_idx == GID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr     <= '0;
      o_rd_wren  <= 1'b0;
      o_rd_addr  <= '0;
      o_rd_data  <= '0;
      o_grant_id <= '0;
    end else begin
      o_rd_wren <= grant_vld;
      if (grant_vld) begin
        rr_ptr     <= ptr_nxt;
        o_rd_addr  <= req_addr[grant_idx];
        o_rd_data  <= req_data[grant_idx];
        o_grant_id <= grant_idx;
      end
    end
  end

`ifdef REGWB_FWD_EN
  // The output-stage write is not visible to the regfile read until after it commits.
  function automatic logic [DATA_W-1:0] fwd_sel(input logic [ADDR_W-1:0] rs_addr,
                                                input logic [DATA_W-1:0] rf_data);
    if (rs_addr == '0)                          return '0;
    else if (o_rd_wren && o_rd_addr == rs_addr) return o_rd_data;
    else                                        return rf_data;
  endfunction

  always_comb begin
    o_rs1_data = fwd_sel(i_rs1_addr, i_rs1_rf_data);
    o_rs2_data = fwd_sel(i_rs2_addr, i_rs2_rf_data);
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, reset-mid-write sequence, and random traffic vs a reference model.
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int GW = 2;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_stall = 1'b0;
  logic [N-1:0]  i_req_valid = '0;
  logic [N-1:0]  o_req_ready;
  logic [N*AW-1:0] i_req_addr = '0;
  logic [N*DW-1:0] i_req_data = '0;
  logic [AW-1:0] o_rd_addr;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_wren;
  logic [GW-1:0] o_grant_id;
`ifdef REGWB_FWD_EN
  logic [AW-1:0] i_rs1_addr = '0, i_rs2_addr = '0;
  logic [DW-1:0] i_rs1_rf_data = '0, i_rs2_rf_data = '0;
  logic [DW-1:0] o_rs1_data, o_rs2_data;
`endif

  int n_chk = 0;
  int n_fail = 0;
  logic [DW-1:0] rf [32] = '{default: '0};

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data), .o_rd_wren(o_rd_wren),
    .o_grant_id(o_grant_id)
`ifdef REGWB_FWD_EN
    , .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .i_rs1_rf_data(i_rs1_rf_data), .i_rs2_rf_data(i_rs2_rf_data),
    .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Regfile stand-in: commits whatever the output stage presents.
  always @(posedge i_clk) if (o_rd_wren) rf[o_rd_addr] <= o_rd_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          stall;
    logic [N-1:0]  valid;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] data;
    logic [N-1:0]  rdy;
    logic          wren;
    logic [AW-1:0] oa;
    logic [DW-1:0] od;
    logic [GW-1:0] gid;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic [N-1:0] v,
                              input logic [AW-1:0] a2, a1, a0,
                              input logic [DW-1:0] d2, d1, d0,
                              input logic [N-1:0] r, input logic w,
                              input logic [AW-1:0] oa, input logic [DW-1:0] od,
                              input logic [GW-1:0] g);
    vec_t t;
    t.stall = st; t.valid = v; t.addr = {a2, a1, a0}; t.data = {d2, d1, d0};
    t.rdy = r; t.wren = w; t.oa = oa; t.od = od; t.gid = g;
    return t;
  endfunction

  vec_t tbl [18];

  // Reference model state for the random phase
  int            m_ptr;
  logic [N-1:0]  m_pend;
  logic [AW-1:0] m_addr [N];
  logic [DW-1:0] m_data [N];
  int            m_wait [N];
  logic          e_wren;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [GW-1:0] e_gid;

  initial begin
    tbl[0]  = mk(0, 3'b001, 0, 0, 5, 0, 0, 32'hDEADBEEF, 3'b001, 1, 5, 32'hDEADBEEF, 0);
    tbl[1]  = mk(0, 3'b000, 0, 0, 5, 0, 0, 32'hDEADBEEF, 3'b000, 0, 5, 32'hDEADBEEF, 0);
    tbl[2]  = mk(0, 3'b100, 3, 0, 0, 'hC, 0, 0, 3'b100, 1, 3, 'hC, 2);
    tbl[3]  = mk(0, 3'b111, 3, 2, 1, 'hC, 'hB, 'hA, 3'b001, 1, 1, 'hA, 0);
    tbl[4]  = mk(0, 3'b110, 3, 2, 1, 'hC, 'hB, 'hA, 3'b010, 1, 2, 'hB, 1);
    tbl[5]  = mk(0, 3'b101, 3, 2, 1, 'hC, 'hB, 'hA, 3'b100, 1, 3, 'hC, 2);
    tbl[6]  = mk(0, 3'b011, 3, 2, 1, 'hC, 'hB, 'hA, 3'b001, 1, 1, 'hA, 0);
    tbl[7]  = mk(0, 3'b110, 3, 2, 1, 'hC, 'hB, 'hA, 3'b010, 1, 2, 'hB, 1);
    tbl[8]  = mk(0, 3'b101, 3, 2, 1, 'hC, 'hB, 'hA, 3'b100, 1, 3, 'hC, 2);
    tbl[9]  = mk(0, 3'b001, 0, 0, 4, 0, 0, 'h44, 3'b001, 1, 4, 'h44, 0);
    tbl[10] = mk(0, 3'b110, 7, 0, 0, 'h77, 0, 0, 3'b110, 1, 7, 'h77, 2);
    tbl[11] = mk(0, 3'b001, 0, 0, 6, 0, 0, 'h66, 3'b001, 1, 6, 'h66, 0);
    tbl[12] = mk(1, 3'b011, 0, 8, 6, 0, 'h88, 'h66, 3'b000, 0, 6, 'h66, 0);
    tbl[13] = tbl[12];
    tbl[14] = tbl[12];
    tbl[15] = mk(0, 3'b011, 0, 8, 6, 0, 'h88, 'h66, 3'b010, 1, 8, 'h88, 1);
    tbl[16] = mk(0, 3'b001, 0, 8, 6, 0, 'h88, 'h66, 3'b001, 1, 6, 'h66, 0);
    tbl[17] = mk(0, 3'b000, 0, 8, 6, 0, 'h88, 'h66, 3'b000, 0, 6, 'h66, 0);

    #2;
    chk("reset_wren", o_rd_wren, 0);
    chk("reset_addr", o_rd_addr, 0);
    chk("reset_data", o_rd_data, 0);
    chk("reset_gid", o_grant_id, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Directed table: ready same cycle, registered outputs after the edge
    for (int i = 0; i < 18; i++) begin
      @(negedge i_clk);
      i_stall = tbl[i].stall; i_req_valid = tbl[i].valid;
      i_req_addr = tbl[i].addr; i_req_data = tbl[i].data;
      #1;
      chk($sformatf("v%0d_ready", i), o_req_ready, tbl[i].rdy);
      @(posedge i_clk); #1;
      chk($sformatf("v%0d_wren", i), o_rd_wren, tbl[i].wren);
      chk($sformatf("v%0d_addr", i), o_rd_addr, tbl[i].oa);
      chk($sformatf("v%0d_data", i), o_rd_data, tbl[i].od);
      chk($sformatf("v%0d_gid", i), o_grant_id, tbl[i].gid);
    end
    chk("rf_x0", rf[0], 0);
    chk("rf_x1", rf[1], 'hA);
    chk("rf_x2", rf[2], 'hB);
    chk("rf_x3", rf[3], 'hC);
    chk("rf_x4", rf[4], 'h44);
    chk("rf_x5", rf[5], 32'hDEADBEEF);
    chk("rf_x6", rf[6], 'h66);
    chk("rf_x7", rf[7], 'h77);
    chk("rf_x8", rf[8], 'h88);

    // Reset asserted while a write sits in the output stage (pointer is 1 going in)
    @(negedge i_clk);
    i_req_valid = 3'b001; i_req_addr = {5'd0, 5'd0, 5'd9}; i_req_data = {32'd0, 32'd0, 32'h99};
    @(posedge i_clk); #1;
    chk("rst_pre_wren", o_rd_wren, 1);
    chk("rst_pre_addr", o_rd_addr, 9);
    @(negedge i_clk);
    i_req_valid = '0;
    i_rst_n = 1'b0;
    #1;
    chk("rst_async_wren", o_rd_wren, 0);
    chk("rst_async_addr", o_rd_addr, 0);
    chk("rst_async_data", o_rd_data, 0);
    @(posedge i_clk); #1;
    chk("rst_x9_kept", rf[9], 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_req_valid = 3'b101;
    i_req_addr = {5'd11, 5'd0, 5'd10}; i_req_data = {32'h1111, 32'd0, 32'h1010};
    #1;
    chk("rst_tie_ready", o_req_ready, 3'b001);
    @(posedge i_clk); #1;
    chk("rst_tie_gid", o_grant_id, 0);
    chk("rst_tie_addr", o_rd_addr, 10);

`ifdef REGWB_FWD_EN
    @(negedge i_clk);
    i_req_valid = 3'b001; i_req_addr = {5'd0, 5'd0, 5'd3}; i_req_data = {32'd0, 32'd0, 32'h11};
    @(posedge i_clk); #1;
    i_req_valid = '0;
    i_rs1_addr = 5'd3; i_rs1_rf_data = 32'h0;
    i_rs2_addr = 5'd0; i_rs2_rf_data = 32'h55;
    #1;
    chk("fwd_rs1", o_rs1_data, 'h11);
    chk("fwd_rs2", o_rs2_data, 0);
    i_rs1_addr = 5'd4; i_rs1_rf_data = 32'h44;
    #1;
    chk("fwd_rs1_nohit", o_rs1_data, 'h44);
`endif

    // Random traffic against the reference model, starting from a fresh reset
    @(negedge i_clk);
    i_req_valid = '0; i_stall = 1'b0; i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    m_ptr = 0; m_pend = '0;
    e_wren = 0; e_addr = '0; e_data = '0; e_gid = '0;
    for (int k = 0; k < N; k++) begin m_wait[k] = 0; m_addr[k] = '0; m_data[k] = '0; end

    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [N-1:0] e_rdy;
      int g;
      @(negedge i_clk);
      for (int k = 0; k < N; k++) begin
        if (!m_pend[k] && $urandom_range(0, 2) != 0) begin
          m_pend[k] = 1'b1;
          m_addr[k] = ($urandom_range(0, 3) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
          m_data[k] = $urandom;
        end
        i_req_addr[k*AW +: AW] = m_addr[k];
        i_req_data[k*DW +: DW] = m_data[k];
      end
      i_req_valid = m_pend;
      i_stall = ($urandom_range(0, 7) == 0);

      e_rdy = '0;
      g = -1;
      if (!i_stall) begin
        for (int k = 0; k < N; k++) if (m_pend[k] && m_addr[k] == 0) e_rdy[k] = 1'b1;
        for (int j = 0; j < N; j++) begin
          int k;
          k = (m_ptr + j) % N;
          if (g < 0 && m_pend[k] && m_addr[k] != 0) g = k;
        end
        if (g >= 0) e_rdy[g] = 1'b1;
      end
      #1;
      chk("rnd_ready", o_req_ready, e_rdy);

      for (int k = 0; k < N; k++) begin
        if (!i_stall && m_pend[k] && m_addr[k] != 0 && k != g) m_wait[k]++;
        if (e_rdy[k]) begin
          if (k == g) chk("rnd_starve_bound", (m_wait[k] <= N - 1), 1);
          m_pend[k] = 1'b0;
          m_wait[k] = 0;
        end
      end
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        e_wren = 1'b1; e_addr = m_addr[g]; e_data = m_data[g]; e_gid = GW'(g);
      end else begin
        e_wren = 1'b0;
      end

      @(posedge i_clk); #1;
      chk("rnd_wren", o_rd_wren, e_wren);
      chk("rnd_addr", o_rd_addr, e_addr);
      chk("rnd_data", o_rd_data, e_data);
      chk("rnd_gid", o_grant_id, e_gid);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Arbitrates the single write port of the 32x32 register file among NUM_REQ writeback sources (e.g. ALU, load unit, multi-cycle mul/div).
- Round-robin grant, one write per cycle, valid/ready handshake per requester.
- One registered output stage drives the regfile rd write port directly.
- Sits between the writeback sources and the regfile.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
DATA_W, 32, write data width
ADDR_W, 5, register address width
GID_W, $clog2(NUM_REQ), width of grant id (localparam)

Ports:
i_clk  in  1  global clock, rising edge
i_rst_n  in  1  global reset, asynchronous, active-low
i_stall  in  1  pipeline hold; suppresses all grants while high
i_req_valid  in  NUM_REQ  per-requester write request
o_req_ready  out  NUM_REQ  per-requester accept; a transfer happens when valid && ready
i_req_addr  in  NUM_REQ*ADDR_W  packed destination addresses; requester k at [k*ADDR_W +: ADDR_W]
i_req_data  in  NUM_REQ*DATA_W  packed write data; requester k at [k*DATA_W +: DATA_W]
o_rd_addr  out  ADDR_W  regfile write address (registered)
o_rd_data  out  DATA_W  regfile write data (registered)
o_rd_wren  out  1  regfile write enable (registered)
o_grant_id  out  GID_W  index of the requester whose write is in the output stage (registered)

Behaviour:
- Reset (async assert, sync release): o_rd_wren=0, o_rd_addr=0, o_rd_data=0, o_grant_id=0, RR pointer=0 (requester 0 highest priority). A write in the output stage at reset assertion is discarded.
- Zero-address requests: requester k with valid=1 and addr=0 gets o_req_ready[k]=1 in the same cycle, unless i_stall=1.
  - Several such requesters are accepted in parallel, outside arbitration.
  - They produce no write and do not move the pointer.
- Arbitration: applies to valid requesters with addr!=0 ("eligible").
  - Search starts at the pointer and wraps modulo NUM_REQ; the first eligible requester k gets o_req_ready[k]=1 (combinational, same cycle).
  - All other nonzero-address requesters see ready=0.
  - Pointer updates to (k+1) mod NUM_REQ at the clock edge.
  - With no eligible requester, the pointer holds.
- Output stage:
  - If a grant occurs in cycle N: o_rd_wren=1, o_rd_addr/o_rd_data = granted values, and o_grant_id=k, all in cycle N+1. The regfile commits at the end of N+1.
  - With no grant: o_rd_wren=0, while o_rd_addr, o_rd_data and o_grant_id hold.
- Throughput: one write per cycle, with no bubble between back-to-back grants.
- i_stall=1: all o_req_ready=0 (zero-address requests included), pointer holds, o_rd_wren=0 next cycle.
- Requesters must hold valid/addr/data stable until accepted. The arbiter does not buffer unaccepted requests.
- Same destination from two requesters in one cycle: serialized in grant order. The later grant wins in the regfile; no merging.
- Starvation bound: a continuously valid eligible requester is granted within NUM_REQ cycles when i_stall=0.

Optional Feature:
REGWB_FWD_EN
- Defined: adds ports i_rs1_addr/i_rs2_addr (ADDR_W, in), i_rs1_rf_data/i_rs2_rf_data (DATA_W, in, from the regfile async read), and o_rs1_data/o_rs2_data (DATA_W, out).
  - Combinational: o_rsX_data = o_rd_data if o_rd_wren && o_rd_addr==i_rsX_addr && i_rsX_addr!=0.
  - Otherwise o_rsX_data = 0 if i_rsX_addr==0, else i_rsX_rf_data.
  - This covers the cycle where the write is not yet visible to the regfile read.
- Undefined: these ports and the logic are absent; all other behaviour is identical.

Test Plan:
1. Release reset; req0 valid, addr=5, data=0xDEADBEEF -> ready[0]=1 same cycle; next cycle o_rd_wren=1, o_rd_addr=5, o_rd_data=0xDEADBEEF, o_grant_id=0; following cycle o_rd_wren=0.
2. Requesters 0,1,2 continuously valid (addrs 1,2,3, data 0xA/0xB/0xC), each dropping valid after one accept then re-raising -> grant order 0,1,2,0,1,2; o_rd_wren=1 every cycle; regfile x1=0xA, x2=0xB, x3=0xC.
3. Same cycle: req1 addr=0 and req2 addr=7 data=0x77 (pointer=1) -> ready[1]=1 and ready[2]=1; only write is x7=0x77; pointer becomes 0.
4. i_stall=1 for 3 cycles with req0/req1 valid (pointer=1) -> all ready=0, o_rd_wren=0; after release, req1 is granted first.
5. Assert i_rst_n=0 while o_rd_wren=1 (addr 9) -> o_rd_wren=0 immediately without a clock; x9 unchanged; after release, req0 wins a tie with req2.
6. REGWB_FWD_EN: output stage holds x3=0x11, i_rs1_addr=3 with rf_data 0x0, i_rs2_addr=0 with rf_data 0x55 -> o_rs1_data=0x11, o_rs2_data=0.
